// File: rtl/middle_ram_pingpong_if.sv
// middle_ram_pingpong_if: writer/reader bus of the ping-pong frame store.
// Handshake: a write is accepted on a rising edge when iWren=1 and
// oWrready=1 (otherwise it is dropped); a read request with iRdreq=1 is
// always accepted and answered one cycle later with oRdvalid=1; iRdlast and
// iWrlast are frame-level markers, not handshakes.
interface middle_ram_pingpong_if #(
    parameter int DATA_W = 8,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 8
);
    logic              iWren;
    logic [COL_W-1:0]  iWrcol;
    logic [ROW_W-1:0]  iWrrow;
    logic [DATA_W-1:0] iWrdata;
    logic              iWrlast;
    logic              oWrready;
    logic              iRdreq;
    logic [COL_W-1:0]  iRdcol;
    logic [ROW_W-1:0]  iRdrow;
    logic [DATA_W-1:0] oRddata;
    logic              oRdvalid;
    logic              iRdlast;
    logic              oFrameReady;
    logic              oWrbank;
    logic              oSwap;
    logic              oRangeErr;

    // Writer/reader stages drive the requests.
    modport master (
        output iWren, iWrcol, iWrrow, iWrdata, iWrlast,
        output iRdreq, iRdcol, iRdrow, iRdlast,
        input  oWrready, oRddata, oRdvalid, oFrameReady, oWrbank, oSwap, oRangeErr
    );

    // Frame store answers them.
    modport slave (
        input  iWren, iWrcol, iWrrow, iWrdata, iWrlast,
        input  iRdreq, iRdcol, iRdrow, iRdlast,
        output oWrready, oRddata, oRdvalid, oFrameReady, oWrbank, oSwap, oRangeErr
    );
endinterface

// File: rtl/middle_ram_pingpong.sv
// middle_ram_pingpong: double-buffered frame store. The writer fills bank
// oWrbank while the reader reads bank ~oWrbank; banks swap under a frame
// handshake (IDLE/HOLD/PEND FSM) so a reader never sees a partial frame.
// Optional macro MIDDLE_RAM_RANGE_CHECK_EN drops out-of-range writes, zeroes
// out-of-range reads and raises the sticky oRangeErr flag.
module middle_ram_pingpong #(
    parameter int DATA_W = 8,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 8,
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256
) (
    input  logic                  clock,
    input  logic                  reset_n,
    middle_ram_pingpong_if.slave  bus,
    output logic [1:0]            oState
);
    localparam int AW    = COL_W + ROW_W + 1;
    localparam int DEPTH = 1 << AW;

    if (WIDTH < 1 || WIDTH > (1 << COL_W)) begin : g_bad_width
        $error("middle_ram_pingpong: WIDTH does not fit in COL_W");
    end
    if (HEIGHT < 1 || HEIGHT > (1 << ROW_W)) begin : g_bad_height
        $error("middle_ram_pingpong: HEIGHT does not fit in ROW_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // read bank empty, writer filling
        ST_HOLD = 2'd1,   // read bank full, writer filling
        ST_PEND = 2'd2    // both banks full, waiting for reader to finish
    } state_t;

    state_t            state_q, state_d;
    logic              wrbank_q, wrbank_d;
    logic              swap_q, swap_d;
    logic              rdvalid_q;
    logic [DATA_W-1:0] rddata_q;
    logic              rangeerr_q, rangeerr_d;
    logic              wrready;
    logic              wrfin;
    logic              wr_en;
    logic              rd_zero;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    assign wrready = (state_q != ST_PEND);
    // A frame-completing write counts even if range checking drops its data.
    assign wrfin   = bus.iWren & bus.iWrlast & wrready;
    assign wr_addr = {wrbank_q, bus.iWrrow, bus.iWrcol};
    assign rd_addr = {~wrbank_q, bus.iRdrow, bus.iRdcol};

`ifdef MIDDLE_RAM_RANGE_CHECK_EN
    logic wr_oor;
    logic rd_oor;
    assign wr_oor     = (32'(bus.iWrcol) >= 32'(WIDTH)) || (32'(bus.iWrrow) >= 32'(HEIGHT));
    assign rd_oor     = (32'(bus.iRdcol) >= 32'(WIDTH)) || (32'(bus.iRdrow) >= 32'(HEIGHT));
    assign wr_en      = reset_n & bus.iWren & wrready & ~wr_oor;
    assign rd_zero    = rd_oor;
    assign rangeerr_d = rangeerr_q | (bus.iWren & wrready & wr_oor) | (bus.iRdreq & rd_oor);
`else
    assign wr_en      = reset_n & bus.iWren & wrready;
    assign rd_zero    = 1'b0;
    assign rangeerr_d = 1'b0;
`endif

    // Frame FSM next state: decides bank swaps from wrfin / iRdlast.
    always_comb begin
        state_d = state_q;
        swap_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (wrfin) begin
                    state_d = ST_HOLD;
                    swap_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (wrfin && bus.iRdlast) begin
                    state_d = ST_HOLD;
                    swap_d  = 1'b1;
                end else if (wrfin) begin
                    state_d = ST_PEND;
                end else if (bus.iRdlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (bus.iRdlast) begin
                    state_d = ST_HOLD;
                    swap_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        wrbank_d = wrbank_q ^ swap_d;
    end

    // Frame FSM state, bank select, swap pulse and sticky range flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wrbank_q   <= 1'b0;
            swap_q     <= 1'b0;
            rangeerr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrbank_q   <= wrbank_d;
            swap_q     <= swap_d;
            rangeerr_q <= rangeerr_d;
        end
    end

    // Pixel storage; lands in the pre-swap bank on the completing edge.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= bus.iWrdata;
        end
    end

    // Registered read port; data holds between requests.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rdvalid_q <= 1'b0;
            rddata_q  <= '0;
        end else begin
            rdvalid_q <= bus.iRdreq;
            if (bus.iRdreq) begin
                rddata_q <= rd_zero ? '0 : mem_q[rd_addr];
            end
        end
    end

    assign bus.oWrready    = wrready;
    assign bus.oFrameReady = (state_q != ST_IDLE);
    assign bus.oWrbank     = wrbank_q;
    assign bus.oSwap       = swap_q;
    assign bus.oRdvalid    = rdvalid_q;
    assign bus.oRddata     = rddata_q;
    assign bus.oRangeErr   = rangeerr_q;
    assign oState          = state_q;
endmodule

// File: tb/tb_middle_ram_pingpong.sv
// tb_middle_ram_pingpong: table of frame-handshake vectors plus directed
// sequences for frame fill, pending swap, mid-frame reset and range check.
// Reads are checked through an expected-data queue.
module tb_middle_ram_pingpong;
    localparam int DATA_W = 8;
    localparam int COL_W  = 8;
    localparam int ROW_W  = 8;
    localparam int HEIGHT = 256;
`ifdef MIDDLE_RAM_RANGE_CHECK_EN
    localparam int WIDTH  = 200;
    localparam bit RC     = 1'b1;
`else
    localparam int WIDTH  = 256;
    localparam bit RC     = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] dbg_state;

    middle_ram_pingpong_if #(.DATA_W(DATA_W), .COL_W(COL_W), .ROW_W(ROW_W)) bus ();

    middle_ram_pingpong #(
        .DATA_W(DATA_W), .COL_W(COL_W), .ROW_W(ROW_W), .WIDTH(WIDTH), .HEIGHT(HEIGHT)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus),
        .oState (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    // scoreboard
    logic [DATA_W-1:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       wren;
        logic       last;
        logic       rdlast;
        logic [1:0] st;
        logic       fr;
        logic       wrr;
        logic       bank;
        logic       swap;
    } fsm_vec_t;

    fsm_vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.iWren   = 1'b0;
        bus.iWrlast = 1'b0;
        bus.iWrcol  = '0;
        bus.iWrrow  = '0;
        bus.iWrdata = '0;
        bus.iRdreq  = 1'b0;
        bus.iRdcol  = '0;
        bus.iRdrow  = '0;
        bus.iRdlast = 1'b0;
    endtask

    // One clock edge; read responses are checked against the queue.
    task automatic tick();
        logic req_was;
        req_was = bus.iRdreq & reset_n;
        @(posedge clock);
        #1;
        check("rdvalid", {31'd0, bus.oRdvalid}, {31'd0, req_was});
        if (req_was && exp_q.size() > 0) begin
            check("rddata", {24'd0, bus.oRddata}, {24'd0, exp_q.pop_front()});
        end
    endtask

    // driver: one cycle of arbitrary write/read/rdlast activity
    task automatic cycle(input logic wren, input int wrow, input int wcol, input logic [7:0] wdata,
                         input logic last, input logic rdreq, input int rrow, input int rcol,
                         input logic [7:0] rexp, input logic rdlast);
        bus.iWren   = wren;
        bus.iWrrow  = ROW_W'(wrow);
        bus.iWrcol  = COL_W'(wcol);
        bus.iWrdata = wdata;
        bus.iWrlast = last;
        bus.iRdreq  = rdreq;
        bus.iRdrow  = ROW_W'(rrow);
        bus.iRdcol  = COL_W'(rcol);
        bus.iRdlast = rdlast;
        if (rdreq) exp_q.push_back(rexp);
        tick();
        idle_inputs();
    endtask

    task automatic wr(input int row, input int col, input logic [7:0] data, input logic last);
        cycle(1'b1, row, col, data, last, 1'b0, 0, 0, 8'h00, 1'b0);
    endtask

    task automatic rd(input int row, input int col, input logic [7:0] exp);
        cycle(1'b0, 0, 0, 8'h00, 1'b0, 1'b1, row, col, exp, 1'b0);
    endtask

    task automatic check_ctl(input string tag, input logic [1:0] st, input logic fr,
                             input logic wrr, input logic bank, input logic swap);
        check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, st});
        check({tag, "_frameready"}, {31'd0, bus.oFrameReady}, {31'd0, fr});
        check({tag, "_wrready"}, {31'd0, bus.oWrready}, {31'd0, wrr});
        check({tag, "_wrbank"}, {31'd0, bus.oWrbank}, {31'd0, bank});
        check({tag, "_swap"}, {31'd0, bus.oSwap}, {31'd0, swap});
    endtask

    initial begin
        logic [7:0] pix;
        //                wren  last  rdlast st    fr    wrr   bank  swap
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1};

        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        check_ctl("reset", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_rddata", {24'd0, bus.oRddata}, 32'd0);
        check("reset_rangeerr", {31'd0, bus.oRangeErr}, 32'd0);
        reset_n = 1'b1;

        // Frame 1: (r+c)&0xFF over rows 0..7, completed at the last active pixel.
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                pix = 8'((r + c) & 8'hFF);
                wr(r, c, pix, 1'b0);
            end
        end
        wr(HEIGHT - 1, WIDTH - 1, 8'((HEIGHT - 1 + WIDTH - 1) & 8'hFF), 1'b1);
        check_ctl("frame1_done", 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("frame1_swap_pulse", {31'd0, bus.oSwap}, 32'd0);
        rd(3, 4, 8'h07);
        rd(7, WIDTH - 1, 8'((7 + WIDTH - 1) & 8'hFF));
        rd(0, 0, 8'h00);
        rd(HEIGHT - 1, WIDTH - 1, 8'((HEIGHT - 1 + WIDTH - 1) & 8'hFF));

        // Frame 2: 0xA5, completed without iRdlast -> PEND.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                wr(r, c, 8'hA5, 1'b0);
            end
        end
        wr(HEIGHT - 1, WIDTH - 1, 8'hA5, 1'b1);
        check_ctl("frame2_pend", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        wr(0, 0, 8'h00, 1'b0);
        check_ctl("pend_drop", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        rd(0, 0, 8'h00);
        rd(3, 4, 8'h07);
        // iRdlast with a read in the swap cycle: the read still sees frame 1.
        cycle(1'b0, 0, 0, 8'h00, 1'b0, 1'b1, 1, 4, 8'h05, 1'b1);
        check_ctl("pend_swap", 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        rd(0, 0, 8'hA5);
        rd(1, 4, 8'hA5);

        // Frame-handshake table, writes parked at (10,10).
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].wren, 10, 10, 8'h99, vecs[i].last, 1'b0, 0, 0, 8'h00, vecs[i].rdlast);
            check_ctl($sformatf("vec%0d", i), vecs[i].st, vecs[i].fr, vecs[i].wrr,
                      vecs[i].bank, vecs[i].swap);
        end

        // Mid-frame reset.
        rd(0, 0, 8'hA5);
        wr(5, 5, 8'h42, 1'b0);
        reset_n = 1'b0;
        bus.iWren = 1'b1;
        bus.iWrrow = 8'd6;
        bus.iWrcol = 8'd6;
        bus.iWrdata = 8'h43;
        tick();
        idle_inputs();
        check_ctl("midreset", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("midreset_rddata", {24'd0, bus.oRddata}, 32'd0);
        check("midreset_rangeerr", {31'd0, bus.oRangeErr}, 32'd0);
        reset_n = 1'b1;
        wr(1, 1, 8'h3C, 1'b1);
        check_ctl("after_reset_frame", 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        rd(1, 1, 8'h3C);

        // Range checking (only active when the macro is defined).
        wr(1, 199, 8'h11, 1'b0);
        check("range_ok_write", {31'd0, bus.oRangeErr}, 32'd0);
        wr(1, 200, 8'h55, 1'b1);
        check("range_wrfin_state", {30'd0, dbg_state}, 32'd2);
        check("range_write_err", {31'd0, bus.oRangeErr}, {31'd0, RC});
        cycle(1'b0, 0, 0, 8'h00, 1'b0, 1'b0, 0, 0, 8'h00, 1'b1);
        check_ctl("range_swap", 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        rd(1, 199, 8'h11);
        rd(1, 200, RC ? 8'h00 : 8'h55);
`ifdef MIDDLE_RAM_RANGE_CHECK_EN
        rd(1, 210, 8'h00);
`endif
        check("range_err_final", {31'd0, bus.oRangeErr}, {31'd0, RC});
        tick();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
